// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;
   localparam int DATA_W = 16;
   localparam int BE_W = 2;
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;
   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} arb_state_t;
endpackage

// File: rtl/sdram_arb_owner_fifo.sv
// sdram_arb_owner_fifo: 1-bit FIFO recording which master owns each outstanding read
module sdram_arb_owner_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic empty,
   output logic full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DEPTH-1:0] mem;
   logic [PW-1:0] wp, rp;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign head = mem[rp];
   // ring buffer; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mem <= '0;
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) mem[wp] <= din;
         wp <= wp + PW'(do_push);
         rp <= rp + PW'(do_pop);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master (A high, B low priority) arbiter onto one SDRAM Avalon port; SDRAM_ARB_STARVE_GUARD_EN adds B starvation guard
import sdram_arb_pkg::*;
module sdram_port_arbiter #(
   parameter int ADDR_W = 24,
   parameter int MAX_PEND = 4,
   parameter int STARVE_LIMIT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic [ADDR_W-1:0] a_address,
   input  logic a_read,
   input  logic a_write,
   input  logic [DATA_W-1:0] a_writedata,
   input  logic [BE_W-1:0] a_byteenable,
   output logic a_waitrequest,
   output logic [DATA_W-1:0] a_readdata,
   output logic a_readdatavalid,
   input  logic [ADDR_W-1:0] b_address,
   input  logic b_read,
   input  logic b_write,
   input  logic [DATA_W-1:0] b_writedata,
   input  logic [BE_W-1:0] b_byteenable,
   output logic b_waitrequest,
   output logic [DATA_W-1:0] b_readdata,
   output logic b_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic s_read,
   output logic s_write,
   output logic [DATA_W-1:0] s_writedata,
   output logic [BE_W-1:0] s_byteenable,
   input  logic s_waitrequest,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic s_readdatavalid,
   input  logic err_clr,
   output logic err_orphan
);
   localparam int CW = $clog2(MAX_PEND+1);
   if (MAX_PEND < 2 || (MAX_PEND & (MAX_PEND-1)) != 0) begin : g_bad_pend
      $error("MAX_PEND must be a power of two >= 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("STARVE_LIMIT must be >= 1");
   end
   arb_state_t state;
   logic gnt_a, gnt_b, room, a_ok, b_ok, pick_a, pick_b;
   logic push, pop, head, empty, full;
   logic [CW-1:0] count;
   assign gnt_a = state == GNT_A;
   assign gnt_b = state == GNT_B;
   assign room = count < CW'(MAX_PEND);
   assign a_ok = a_write | (a_read & room);
   assign b_ok = b_write | (b_read & room);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT+1);
   logic [SW-1:0] starve_cnt;
   logic starve;
   assign starve = starve_cnt == SW'(STARVE_LIMIT);
   assign pick_b = b_ok & (starve | ~a_ok);
   // cycles B has waited ungranted, saturating; cleared while B holds the grant
   always_ff @(posedge clk or posedge reset)
      if (reset) starve_cnt <= '0;
      else if (gnt_b) starve_cnt <= '0;
      else if ((b_read | b_write) && !starve) starve_cnt <= starve_cnt + 1'b1;
`else
   assign pick_b = b_ok & ~a_ok;
`endif
   assign pick_a = a_ok & ~pick_b;
   // grant FSM: arbitrate in IDLE, hold the grant until the downstream accepts
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else if (state == IDLE) state <= pick_b ? GNT_B : pick_a ? GNT_A : IDLE;
      else if (!s_waitrequest) state <= IDLE;
   assign s_address = gnt_b ? b_address : a_address;
   assign s_writedata = gnt_b ? b_writedata : a_writedata;
   assign s_byteenable = gnt_b ? b_byteenable : a_byteenable;
   assign s_read = (gnt_a & a_read) | (gnt_b & b_read);
   assign s_write = (gnt_a & a_write) | (gnt_b & b_write);
   assign a_waitrequest = gnt_a ? s_waitrequest : 1'b1;
   assign b_waitrequest = gnt_b ? s_waitrequest : 1'b1;
   assign push = (gnt_a | gnt_b) & ~s_waitrequest & s_read & ~full;
   assign pop = s_readdatavalid & ~empty;
   assign a_readdata = s_readdata;
   assign b_readdata = s_readdata;
   assign a_readdatavalid = pop & (head == OWNER_A);
   assign b_readdatavalid = pop & (head == OWNER_B);
   sdram_arb_owner_fifo #(.DEPTH(MAX_PEND)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .din(gnt_b ? OWNER_B : OWNER_A),
      .pop(pop),
      .head(head),
      .count(count),
      .empty(empty),
      .full(full)
   );
   // sticky orphan-response flag; a new orphan beats a simultaneous clear
   always_ff @(posedge clk or posedge reset)
      if (reset) err_orphan <= 1'b0;
      else if (s_readdatavalid && empty) err_orphan <= 1'b1;
      else if (err_clr) err_orphan <= 1'b0;
endmodule
